// File: rtl/rr_arbiter_4.sv
//==============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with a two-state
//               (IDLE/BUSY) controller and a bounded grant tenure.
//               A grant is released by DONE, by the holder dropping its
//               request, or by the tenure counter reaching HOLD_MAX-1.
//               Release by the counter alone pulses TIMEOUT for one cycle.
//               Every release is followed by at least one IDLE cycle before
//               the next arbitration.
// Ports       : CLK     - clock; all state changes on its rising edge
//               RST     - asynchronous active-high reset
//               REQ     - per-requester request levels (bit i = requester i)
//               DONE    - release pulse from the current grant holder
//               G       - grant active
//               S1, S0  - granted index {S1,S0}, valid while G=1
//               GNT     - one-hot grant, decode of {S1,S0} gated by G
//               TIMEOUT - one-cycle pulse on a counter-forced release
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 15     // max grant tenure, 1..255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic       G,
    output logic       S1,
    output logic       S0,
    output logic [3:0] GNT,
    output logic       TIMEOUT
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Tenure count at which the grant is forcibly released.
    localparam logic [7:0] C_CNT_LAST = 8'(HOLD_MAX - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q,   ptr_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [1:0]  sel_q,   sel_d;
    logic [3:0]  gnt_q,   gnt_d;
    logic        to_q,    to_d;

    logic [1:0]  w_win_idx;
    logic        w_cnt_hit;
    logic        w_hold_req;
    logic        w_release;

    // Priority pick: scan from lowest to highest priority so the last hit,
    // i.e. the one closest to PTR, wins.
    always_comb begin
        logic [1:0] w_idx;
        w_win_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            w_idx = ptr_q + 2'(k);
            if (REQ[w_idx]) begin
                w_win_idx = w_idx;
            end
        end
    end

    assign w_cnt_hit  = (cnt_q == C_CNT_LAST);
    assign w_hold_req = REQ[sel_q];
    assign w_release  = DONE || !w_hold_req || w_cnt_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // DONE is ignored here; only a nonzero REQ starts a grant.
                if (REQ != 4'b0000) begin
                    state_d = BUSY;
                    sel_d   = w_win_idx;
                    gnt_d   = 4'b0001 << w_win_idx;
                    cnt_d   = 8'd0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    // DONE and a dropped request both override the timeout.
                    to_d    = w_cnt_hit && !DONE && w_hold_req;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign G       = (state_q == BUSY);
    assign S1      = sel_q[1];
    assign S0      = sel_q[0];
    assign GNT     = gnt_q;
    assign TIMEOUT = to_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
//==============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed testbench for rr_arbiter_4 (HOLD_MAX = 4).
//               Observed word is {G, S1, S0, GNT[3:0], TIMEOUT}.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       g, s1, s0, tmo;
    logic [3:0] gnt;

    int n_vec = 0;
    int n_err = 0;

    rr_arbiter_4 #(.HOLD_MAX(4)) u_dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .DONE    (done),
        .G       (g),
        .S1      (s1),
        .S0      (s0),
        .GNT     (gnt),
        .TIMEOUT (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pk(input logic gv, input logic [1:0] sv,
                                      input logic [3:0] gn, input logic tv);
        return {gv, sv, gn, tv};
    endfunction

    function automatic logic [7:0] obs();
        return {g, s1, s0, gnt, tmo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle structural checks on the grant outputs.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot", {7'd0, ($countones(gnt) <= 1)}, 8'd1);
            chk("gnt_decode", {4'd0, gnt}, g ? {4'd0, 4'b0001 << {s1, s0}} : 8'd0);
        end
    end

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;

        // Initial reset: outputs must clear before any clock edge.
        #1 rst = 1'b1;
        #1 chk("reset_state", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0));
        tick();
        tick();
        rst = 1'b0;

        // Full request set with DONE each grant: 0,1,2,3,0 with idle gaps.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] idx;
            idx  = 2'(i);
            done = 1'b0;
            tick();
            chk("rr_grant", obs(), pk(1'b1, idx, 4'b0001 << idx, 1'b0));
            done = 1'b1;
            tick();
            chk("rr_release", obs(), pk(1'b0, idx, 4'b0000, 1'b0));
        end
        done = 1'b0;
        req  = 4'b0000;

        // Fresh reset, single requester 2, then pointer advances to 3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("grant_idx2", obs(), pk(1'b1, 2'd2, 4'b0100, 1'b0));
        done = 1'b1;
        tick();
        chk("done_release", obs(), pk(1'b0, 2'd2, 4'b0000, 1'b0));
        done = 1'b0;
        req  = 4'b1111;
        tick();
        chk("ptr_3_first", obs(), pk(1'b1, 2'd3, 4'b1000, 1'b0));
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;

        // Idle hold with no requests; DONE in IDLE is ignored.
        tick();
        chk("idle_hold", obs(), pk(1'b0, 2'd3, 4'b0000, 1'b0));
        done = 1'b1;
        tick();
        chk("idle_done_ign", obs(), pk(1'b0, 2'd3, 4'b0000, 1'b0));
        done = 1'b0;

        // Timeout: PTR=0, REQ=0001 held -> four busy cycles then TIMEOUT.
        req = 4'b0001;
        tick();
        chk("to_busy1", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        tick();
        chk("to_busy2", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        tick();
        chk("to_busy3", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        tick();
        chk("to_busy4", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        tick();
        chk("to_release", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b1));
        tick();
        chk("to_regrant", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));

        // Timeout coinciding with DONE: release without TIMEOUT.
        tick();
        tick();
        tick();
        chk("co_busy4", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        done = 1'b1;
        tick();
        chk("co_release", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0));
        done = 1'b0;

        // PTR=1: grant 2; extra non-granted request is ignored; drop releases.
        req = 4'b0100;
        tick();
        chk("drop_grant", obs(), pk(1'b1, 2'd2, 4'b0100, 1'b0));
        req = 4'b0101;
        tick();
        chk("nongrant_ign", obs(), pk(1'b1, 2'd2, 4'b0100, 1'b0));
        req = 4'b0001;
        tick();
        chk("drop_release", obs(), pk(1'b0, 2'd2, 4'b0000, 1'b0));
        tick();
        chk("wrap_to_0", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0));
        req = 4'b0000;
        tick();
        chk("drop_release2", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0));

        // PTR=1: grant 3, then asynchronous reset between edges.
        req = 4'b1000;
        tick();
        chk("grant_idx3", obs(), pk(1'b1, 2'd3, 4'b1000, 1'b0));
        #2 rst = 1'b1;
        #1 chk("async_reset", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0));
        req = 4'b1010;
        #2 rst = 1'b0;
        tick();
        chk("post_rst_idx1", obs(), pk(1'b1, 2'd1, 4'b0010, 1'b0));
        req = 4'b0000;
        tick();
        chk("final_release", obs(), pk(1'b0, 2'd1, 4'b0000, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
